issue_scoreboard: RTL and testbench
===================================

Name: issue_scoreboard

Overview:
- Per-register in-flight tracker for the dual-issue pipeline; generates the scoreboard-derived hazard flags (raw/waw/war/load_use per slot) consumed by the issue unit.
- Entries are set on issue, cleared on writeback, and time-tracked for load results.
- Sits in ID, alongside the issue unit and register file.

Parameters:
- NUM_REGS, 32, architectural register count (x0 never tracked)
- LOAD_LAT, 2, cycles after load issue before its result is forwardable (1..7)
- CNT_W, 3, width of per-register load countdown

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  squash all in-flight tracking (asserted by branch/jump redirect)
- iss_we0  in  1  slot0 issued this cycle and writes rd (already qualified by issue_slot0 and !stall_if)
- iss_rd0  in  5  slot0 destination
- iss_ld0  in  1  slot0 issued instruction is a load
- iss_we1  in  1  slot1 issued and writes rd
- iss_rd1  in  5  slot1 destination
- iss_ld1  in  1  slot1 issued instruction is a load
- rs1_0, rs2_0, rd_0  in  5 each  slot0 query registers (ID0)
- use_rs1_0, use_rs2_0, use_rd_0  in  1 each  slot0 query enables
- rs1_1, rs2_1, rd_1  in  5 each  slot1 query registers (ID1)
- use_rs1_1, use_rs2_1, use_rd_1  in  1 each  slot1 query enables
- wb_we0, wb_we1  in  1 each  writeback port valid
- wb_rd0, wb_rd1  in  5 each  writeback destination
- raw_hazard0, raw_hazard1  out  1  source reads in-flight non-forwardable value
- waw_hazard0, waw_hazard1  out  1  rd already busy
- war_hazard0, war_hazard1  out  1  constant 0 (operands read in ID; no WAR window exists)
- load_use0, load_use1  out  1  source depends on a load whose countdown is nonzero
- busy_vec  out  NUM_REGS  current busy bits (debug/bench)

Behaviour:
- State per register r (1..31): busy, is_load, cnt[CNT_W-1:0]. Entry 0 is hardwired to all-zero; writes to x0 are ignored.
- Reset (rst=1 at posedge): all entries zero. All outputs are then 0, since they are combinational from zero state.
- Hazard outputs are combinational from current state and queries (zero-latency lookup); state updates at posedge.
- src_hit(s) = use_s && s!=0 && busy[s].
- load_use_k = OR over enabled sources of (src_hit && is_load && cnt!=0).
- raw_hazard_k = OR over enabled sources of src_hit; see Optional Feature.
- waw_hazard_k = use_rd_k && rd_k!=0 && busy[rd_k].
- Queries see pre-update state only; same-cycle issue or wb effects are not bypassed into lookup. Slot0-to-slot1 intra-bundle checks belong to the issue unit, not here.
- Per-cycle update order, lowest to highest priority:
  - Decrement every nonzero cnt (saturating at 0).
  - Writeback clear: wb_weN && wb_rdN!=0 clears busy, is_load, cnt. Both ports naming the same reg: single clear.
  - Issue set slot0, then slot1: busy=1, is_load=iss_ld, cnt = iss_ld ? LOAD_LAT : 0. Slot1 overrides slot0 on the same rd (younger wins).
- Issue to a reg being written back in the same cycle: issue wins, entry stays busy.
- flush: clears all entries at posedge, overriding same-cycle issue sets. The redirect logic asserts flush in the redirecting instruction's writeback cycle, so no surviving producer is lost.
- rst overrides flush and everything else. Reset mid-countdown zeroes cnt immediately.
- cnt never wraps: LOAD_LAT ≤ 2^CNT_W−1 is enforced by a static assertion.

Optional Feature:
- Macro SB_FORWARD_EN.
- Defined: EX→ID forwarding exists. raw_hazard_k counts only load producers with cnt!=0, so it equals load_use_k. ALU producers never raise raw.
- Undefined: raw_hazard_k asserts whenever any enabled source hits a busy entry, regardless of producer type or cnt.

Decomposition:
- rv32i_pkg gains:
  - SB_CNT_W constant
  - sb_entry_t packed struct {busy, is_load, cnt}
  - SB_LOAD_LAT_DEFAULT
- One natural sub-module: sb_port_check. It is combinational per-slot lookup from the entry array plus three query regs/enables, producing raw/waw/load_use. It is instantiated twice.

Test Plan:
- Reset, then query rs1_0=5 with use=1 -> all hazards 0, busy_vec=0.
- Issue slot0 ALU rd=5, next cycle query rs1_1=5 -> raw_hazard1=1 without SB_FORWARD_EN, 0 with it. Then wb_rd0=5 -> next cycle raw_hazard1=0.
- Issue load rd=7 (LOAD_LAT=2), query rs2_0=7 -> load_use0=1 at +1 cycle, 1 at +2, 0 at +3 while busy still 1 until wb.
- Same cycle: iss_we0 rd=3 and iss_we1 rd=3 (slot1 load) -> busy[3]=1, is_load=1, cnt=2. Concurrently wb_rd0=3 -> entry still busy.
- Issue rd=9, then query use_rd_1 rd_1=9 -> waw_hazard1=1. Query rd_1=0 -> waw_hazard1=0. Issue to rd=0 -> busy_vec unchanged.
- Regs 4,8 busy plus flush asserted with simultaneous iss_we0 rd=10 -> next cycle busy_vec=0. Then rst during active load countdown -> next cycle all state 0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I pipeline types: scoreboard entry layout and defaults.
package rv32i_pkg;

  localparam int SB_REG_W            = 5;
  localparam int SB_CNT_W            = 3;
  localparam int SB_LOAD_LAT_DEFAULT = 2;

  // One scoreboard entry: in-flight flag, producer type, load countdown.
  typedef struct packed {
    logic                busy;
    logic                is_load;
    logic [SB_CNT_W-1:0] cnt;
  } sb_entry_t;

endpackage

// File: rtl/issue_scoreboard_port_check.sv
// sb_port_check: combinational per-slot hazard lookup against the entry array.
// Macro SB_FORWARD_EN: when defined, EX->ID forwarding hides ALU producers,
// so raw only fires on loads whose countdown has not expired.
import rv32i_pkg::*;

module sb_port_check #(
  parameter int NUM_REGS = 32
) (
  input  sb_entry_t [NUM_REGS-1:0] i_ent,
  input  logic [SB_REG_W-1:0]      i_rs1,
  input  logic [SB_REG_W-1:0]      i_rs2,
  input  logic [SB_REG_W-1:0]      i_rd,
  input  logic                     i_use_rs1,
  input  logic                     i_use_rs2,
  input  logic                     i_use_rd,
  output logic                     o_raw,
  output logic                     o_waw,
  output logic                     o_load_use
);

  logic w_hit1, w_hit2, w_lu1, w_lu2;

  // Source hits and load-use per operand; x0 is never a dependency.
  always_comb begin
    w_hit1 = i_use_rs1 && (i_rs1 != '0) && i_ent[i_rs1].busy;
    w_hit2 = i_use_rs2 && (i_rs2 != '0) && i_ent[i_rs2].busy;
    w_lu1  = w_hit1 && i_ent[i_rs1].is_load && (i_ent[i_rs1].cnt != '0);
    w_lu2  = w_hit2 && i_ent[i_rs2].is_load && (i_ent[i_rs2].cnt != '0);
  end

  assign o_load_use = w_lu1 | w_lu2;
  assign o_waw      = i_use_rd && (i_rd != '0) && i_ent[i_rd].busy;

`ifdef SB_FORWARD_EN
  assign o_raw = w_lu1 | w_lu2;
`else
  assign o_raw = w_hit1 | w_hit2;
`endif

endmodule

// File: rtl/issue_scoreboard.sv
// issue_scoreboard: per-register in-flight tracker for the dual-issue ID stage.
// Macro SB_FORWARD_EN (in sb_port_check) selects forwarding-aware raw hazards.
import rv32i_pkg::*;

module issue_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LOAD_LAT = SB_LOAD_LAT_DEFAULT,
  parameter int CNT_W    = SB_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                iss_we0,
  input  logic [SB_REG_W-1:0] iss_rd0,
  input  logic                iss_ld0,
  input  logic                iss_we1,
  input  logic [SB_REG_W-1:0] iss_rd1,
  input  logic                iss_ld1,
  input  logic [SB_REG_W-1:0] rs1_0,
  input  logic [SB_REG_W-1:0] rs2_0,
  input  logic [SB_REG_W-1:0] rd_0,
  input  logic                use_rs1_0,
  input  logic                use_rs2_0,
  input  logic                use_rd_0,
  input  logic [SB_REG_W-1:0] rs1_1,
  input  logic [SB_REG_W-1:0] rs2_1,
  input  logic [SB_REG_W-1:0] rd_1,
  input  logic                use_rs1_1,
  input  logic                use_rs2_1,
  input  logic                use_rd_1,
  input  logic                wb_we0,
  input  logic                wb_we1,
  input  logic [SB_REG_W-1:0] wb_rd0,
  input  logic [SB_REG_W-1:0] wb_rd1,
  output logic                raw_hazard0,
  output logic                raw_hazard1,
  output logic                waw_hazard0,
  output logic                waw_hazard1,
  output logic                war_hazard0,
  output logic                war_hazard1,
  output logic                load_use0,
  output logic                load_use1,
  output logic [NUM_REGS-1:0] busy_vec
);

  localparam int NUM_SLOTS = 2;

  // Countdown must never wrap and the struct layout must match CNT_W.
  generate
    if (LOAD_LAT < 1 || LOAD_LAT > (1 << CNT_W) - 1) begin : g_bad_lat
      $error("issue_scoreboard: LOAD_LAT out of range for CNT_W");
    end
    if (CNT_W != SB_CNT_W) begin : g_bad_cntw
      $error("issue_scoreboard: CNT_W must equal SB_CNT_W");
    end
  endgenerate

  sb_entry_t [NUM_REGS-1:0] r_ent;
  sb_entry_t [NUM_REGS-1:0] w_nxt;

  // Next state: decrement, then wb clear, then slot0 set, then slot1 set.
  always_comb begin
    w_nxt    = r_ent;
    w_nxt[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (r_ent[r].cnt != '0)
        w_nxt[r].cnt = r_ent[r].cnt - SB_CNT_W'(1);
      if ((wb_we0 && wb_rd0 == SB_REG_W'(r)) || (wb_we1 && wb_rd1 == SB_REG_W'(r)))
        w_nxt[r] = '0;
      if (iss_we0 && iss_rd0 == SB_REG_W'(r)) begin
        w_nxt[r].busy    = 1'b1;
        w_nxt[r].is_load = iss_ld0;
        w_nxt[r].cnt     = iss_ld0 ? SB_CNT_W'(LOAD_LAT) : '0;
      end
      if (iss_we1 && iss_rd1 == SB_REG_W'(r)) begin
        w_nxt[r].busy    = 1'b1;
        w_nxt[r].is_load = iss_ld1;
        w_nxt[r].cnt     = iss_ld1 ? SB_CNT_W'(LOAD_LAT) : '0;
      end
    end
  end

  // State register; reset and redirect flush both wipe all tracking.
  always_ff @(posedge clk) begin
    if (rst || flush) r_ent <= '0;
    else              r_ent <= w_nxt;
  end

  // Debug view of busy bits.
  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) busy_vec[r] = r_ent[r].busy;
  end

  logic [NUM_SLOTS-1:0][SB_REG_W-1:0] w_rs1, w_rs2, w_rd;
  logic [NUM_SLOTS-1:0]               w_use_rs1, w_use_rs2, w_use_rd;
  logic [NUM_SLOTS-1:0]               w_raw, w_waw, w_lu;

  assign w_rs1     = {rs1_1, rs1_0};
  assign w_rs2     = {rs2_1, rs2_0};
  assign w_rd      = {rd_1, rd_0};
  assign w_use_rs1 = {use_rs1_1, use_rs1_0};
  assign w_use_rs2 = {use_rs2_1, use_rs2_0};
  assign w_use_rd  = {use_rd_1, use_rd_0};

  generate
    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      sb_port_check #(.NUM_REGS(NUM_REGS)) u_chk (
        .i_ent      (r_ent),
        .i_rs1      (w_rs1[s]),
        .i_rs2      (w_rs2[s]),
        .i_rd       (w_rd[s]),
        .i_use_rs1  (w_use_rs1[s]),
        .i_use_rs2  (w_use_rs2[s]),
        .i_use_rd   (w_use_rd[s]),
        .o_raw      (w_raw[s]),
        .o_waw      (w_waw[s]),
        .o_load_use (w_lu[s])
      );
    end
  endgenerate

  assign raw_hazard0 = w_raw[0];
  assign raw_hazard1 = w_raw[1];
  assign waw_hazard0 = w_waw[0];
  assign waw_hazard1 = w_waw[1];
  assign load_use0   = w_lu[0];
  assign load_use1   = w_lu[1];
  // Operands are read in ID, so no WAR window exists.
  assign war_hazard0 = 1'b0;
  assign war_hazard1 = 1'b0;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard with hand-computed expectations.
module tb_issue_scoreboard;

  logic       clk = 1'b0;
  logic       rst, flush;
  logic       iss_we0, iss_ld0, iss_we1, iss_ld1;
  logic [4:0] iss_rd0, iss_rd1;
  logic [4:0] rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
  logic       use_rs1_0, use_rs2_0, use_rd_0, use_rs1_1, use_rs2_1, use_rd_1;
  logic       wb_we0, wb_we1;
  logic [4:0] wb_rd0, wb_rd1;
  logic       raw_hazard0, raw_hazard1, waw_hazard0, waw_hazard1;
  logic       war_hazard0, war_hazard1, load_use0, load_use1;
  logic [31:0] busy_vec;

  int total = 0;
  int bad   = 0;

`ifdef SB_FORWARD_EN
  localparam logic FWD = 1'b1;
`else
  localparam logic FWD = 1'b0;
`endif

  always #5 clk = ~clk;

  issue_scoreboard dut (
    .clk(clk), .rst(rst), .flush(flush),
    .iss_we0(iss_we0), .iss_rd0(iss_rd0), .iss_ld0(iss_ld0),
    .iss_we1(iss_we1), .iss_rd1(iss_rd1), .iss_ld1(iss_ld1),
    .rs1_0(rs1_0), .rs2_0(rs2_0), .rd_0(rd_0),
    .use_rs1_0(use_rs1_0), .use_rs2_0(use_rs2_0), .use_rd_0(use_rd_0),
    .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
    .use_rs1_1(use_rs1_1), .use_rs2_1(use_rs2_1), .use_rd_1(use_rd_1),
    .wb_we0(wb_we0), .wb_we1(wb_we1), .wb_rd0(wb_rd0), .wb_rd1(wb_rd1),
    .raw_hazard0(raw_hazard0), .raw_hazard1(raw_hazard1),
    .waw_hazard0(waw_hazard0), .waw_hazard1(waw_hazard1),
    .war_hazard0(war_hazard0), .war_hazard1(war_hazard1),
    .load_use0(load_use0), .load_use1(load_use1),
    .busy_vec(busy_vec)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ctl();
    flush = 0; iss_we0 = 0; iss_we1 = 0; iss_ld0 = 0; iss_ld1 = 0;
    iss_rd0 = 0; iss_rd1 = 0; wb_we0 = 0; wb_we1 = 0; wb_rd0 = 0; wb_rd1 = 0;
  endtask

  task automatic idle_q();
    rs1_0 = 0; rs2_0 = 0; rd_0 = 0; rs1_1 = 0; rs2_1 = 0; rd_1 = 0;
    use_rs1_0 = 0; use_rs2_0 = 0; use_rd_0 = 0;
    use_rs1_1 = 0; use_rs2_1 = 0; use_rd_1 = 0;
  endtask

  initial begin
    rst = 1; idle_ctl(); idle_q();
    step(); step();
    rst = 0;

    // Reset state with an active query.
    rs1_0 = 5; use_rs1_0 = 1; #1;
    chk("rst_raw0", 32'(raw_hazard0), 0);
    chk("rst_lu0",  32'(load_use0), 0);
    chk("rst_war0", 32'(war_hazard0), 0);
    chk("rst_busy", busy_vec, 0);
    idle_q();

    // ALU producer rd=5 seen by slot1.
    iss_we0 = 1; iss_rd0 = 5; step(); idle_ctl();
    rs1_1 = 5; use_rs1_1 = 1; #1;
    chk("alu_raw1",  32'(raw_hazard1), 32'(!FWD));
    chk("alu_lu1",   32'(load_use1), 0);
    chk("alu_busy",  busy_vec, 32'h20);
    wb_we0 = 1; wb_rd0 = 5; step(); idle_ctl();
    chk("alu_wb_raw1", 32'(raw_hazard1), 0);
    chk("alu_wb_busy", busy_vec, 0);
    idle_q();

    // Load rd=7 countdown as seen by slot0 rs2.
    iss_we0 = 1; iss_rd0 = 7; iss_ld0 = 1; step(); idle_ctl();
    rs2_0 = 7; use_rs2_0 = 1; #1;
    chk("ld_lu_p1",  32'(load_use0), 1);
    chk("ld_raw_p1", 32'(raw_hazard0), 1);
    step();
    chk("ld_lu_p2",  32'(load_use0), 1);
    step();
    chk("ld_lu_p3",  32'(load_use0), 0);
    chk("ld_raw_p3", 32'(raw_hazard0), 32'(!FWD));
    chk("ld_busy_p3", busy_vec, 32'h80);
    wb_we1 = 1; wb_rd1 = 7; step(); idle_ctl();
    chk("ld_wb_busy", busy_vec, 0);
    idle_q();

    // Dual issue to rd=3 (slot1 load wins) with same-cycle writeback.
    iss_we0 = 1; iss_rd0 = 3; iss_ld0 = 0;
    iss_we1 = 1; iss_rd1 = 3; iss_ld1 = 1;
    wb_we0 = 1; wb_rd0 = 3;
    step(); idle_ctl();
    rs1_0 = 3; use_rs1_0 = 1; #1;
    chk("dual_busy", busy_vec, 32'h8);
    chk("dual_lu_c2", 32'(load_use0), 1);
    step();
    chk("dual_lu_c1", 32'(load_use0), 1);
    step();
    chk("dual_lu_c0", 32'(load_use0), 0);
    // Both wb ports naming reg 3 clear it once.
    wb_we0 = 1; wb_rd0 = 3; wb_we1 = 1; wb_rd1 = 3; step(); idle_ctl();
    chk("dual_wb_busy", busy_vec, 0);
    idle_q();

    // WAW on rd=9; x0 never busy and never tracked.
    iss_we1 = 1; iss_rd1 = 9; step(); idle_ctl();
    rd_1 = 9; use_rd_1 = 1; rd_0 = 9; use_rd_0 = 1; #1;
    chk("waw1_r9", 32'(waw_hazard1), 1);
    chk("waw0_r9", 32'(waw_hazard0), 1);
    rd_1 = 0; #1;
    chk("waw1_r0", 32'(waw_hazard1), 0);
    iss_we0 = 1; iss_rd0 = 0; iss_ld0 = 1; step(); idle_ctl();
    chk("x0_busy", busy_vec, 32'h200);
    rs1_1 = 0; use_rs1_1 = 1; #1;
    chk("x0_raw1", 32'(raw_hazard1), 0);
    wb_we0 = 1; wb_rd0 = 9; step(); idle_ctl();
    idle_q();

    // Flush beats a same-cycle issue.
    iss_we0 = 1; iss_rd0 = 4; iss_we1 = 1; iss_rd1 = 8; step(); idle_ctl();
    chk("pre_flush_busy", busy_vec, 32'h110);
    flush = 1; iss_we0 = 1; iss_rd0 = 10; step(); idle_ctl();
    chk("flush_busy", busy_vec, 0);

    // Reset during a load countdown.
    iss_we0 = 1; iss_rd0 = 6; iss_ld0 = 1; step(); idle_ctl();
    chk("rstld_busy", busy_vec, 32'h40);
    rst = 1; step(); rst = 0;
    rs1_0 = 6; use_rs1_0 = 1; #1;
    chk("rstld_lu0",  32'(load_use0), 0);
    chk("rstld_raw0", 32'(raw_hazard0), 0);
    chk("rstld_busy0", busy_vec, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
